pulse_width_meter: RTL

- Receive-side counterpart of the single-pulse generator.
- Samples an asynchronous optical sync pulse on `pulse_in`, synchronises it, and measures its high width and its rise-to-rise period in `clk_Pulse` cycles.
- Reports each measurement with a one-cycle strobe and checks the width against a programmable window.
- Sits at the optical receiver input, feeding the control/status logic that validates incoming sync pulses.

---
 rtl/pulse_width_meter_pkg.sv | 15 +
 rtl/sync_edge_detect.sv | 31 +++
 rtl/pulse_width_meter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pulse_width_meter_pkg.sv
// Shared definitions for the optical sync-pulse meter and its generator counterpart.
package pulse_width_meter_pkg;

  typedef enum logic [1:0] {
    StWaitLow  = 2'd0,
    StWaitRise = 2'd1,
    StHigh     = 2'd2
  } state_e;

  // Kept in step with the pulse generator so `duration` and `width` share a width.
  localparam int unsigned DefCntW       = 32;
  localparam int unsigned DefSyncStages = 2;
  localparam int unsigned DefPcntW      = 16;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous input with rise/fall detection on the
// synchronised level.
module sync_edge_detect #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_Pulse,
  input  logic rst_n,
  input  logic d,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              s_d_q;

  always_ff @(posedge clk_Pulse or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      s_d_q  <= sync_q[STAGES-1];
    end
  end

  assign s    = sync_q[STAGES-1];
  assign rise = s & ~s_d_q;
  assign fall = ~s & s_d_q;

endmodule

// File: rtl/pulse_width_meter.sv
// Measures high width and rise-to-rise period of an asynchronous sync pulse and
// classifies the width against a programmable window.
module pulse_width_meter
  import pulse_width_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = DefCntW,
  parameter int unsigned SYNC_STAGES = DefSyncStages,
  parameter int unsigned PCNT_W      = DefPcntW
) (
  input  logic              clk_Pulse,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              pulse_in,
  input  logic [CNT_W-1:0]  min_width,
  input  logic [CNT_W-1:0]  max_width,
  output logic [CNT_W-1:0]  width,
  output logic              width_valid,
  output logic              width_ok,
  output logic              err_short,
  output logic              err_long,
  output logic [CNT_W-1:0]  period,
  output logic              period_valid,
  output logic [PCNT_W-1:0] pulse_cnt,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic s, rise, fall;

  sync_edge_detect #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_Pulse (clk_Pulse),
    .rst_n     (rst_n),
    .d         (pulse_in),
    .s         (s),
    .rise      (rise),
    .fall      (fall)
  );

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    wcnt_q, wcnt_d, pcnt_q, pcnt_d;
  logic                sat_q, sat_d, seen_rise_q, seen_rise_d;
  logic [CNT_W-1:0]    width_q, width_d, period_q, period_d;
  logic                wvalid_q, wvalid_d, pvalid_q, pvalid_d;
  logic                ok_q, ok_d, short_q, short_d, long_q, long_d;
  logic [PCNT_W-1:0]   pulse_cnt_q, pulse_cnt_d;

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    pcnt_d      = pcnt_q;
    sat_d       = sat_q;
    seen_rise_d = seen_rise_q;
    width_d     = width_q;
    period_d    = period_q;
    wvalid_d    = 1'b0;
    pvalid_d    = 1'b0;
    ok_d        = ok_q;
    short_d     = short_q;
    long_d      = long_q;
    pulse_cnt_d = pulse_cnt_q;

    if (!enable) begin
      state_d     = StWaitLow;
      wcnt_d      = '0;
      pcnt_d      = '0;
      sat_d       = 1'b0;
      seen_rise_d = 1'b0;
    end else begin
      if (state_q != StWaitLow) begin
        if (rise) begin
          pcnt_d = CNT_W'(1);
        end else if (pcnt_q != CntMax) begin
          pcnt_d = pcnt_q + CNT_W'(1);
        end
      end
      unique case (state_q)
        StWaitLow: begin
          // A pulse already high when armed is skipped entirely.
          if (!s) state_d = StWaitRise;
        end
        StWaitRise: begin
          if (rise) begin
            state_d     = StHigh;
            wcnt_d      = CNT_W'(1);
            sat_d       = 1'b0;
            seen_rise_d = 1'b1;
            if (seen_rise_q) begin
              period_d = pcnt_q;
              pvalid_d = 1'b1;
            end
          end
        end
        StHigh: begin
          if (fall) begin
            state_d     = StWaitRise;
            width_d     = wcnt_q;
            wvalid_d    = 1'b1;
            pulse_cnt_d = pulse_cnt_q + PCNT_W'(1);
            ok_d        = 1'b0;
            short_d     = 1'b0;
            long_d      = 1'b0;
            if (sat_q)                    long_d  = 1'b1;
            else if (wcnt_q < min_width)  short_d = 1'b1;
            else if (wcnt_q > max_width)  long_d  = 1'b1;
            else                          ok_d    = 1'b1;
          end else if (s) begin
            if (wcnt_q == CntMax) sat_d  = 1'b1;
            else                  wcnt_d = wcnt_q + CNT_W'(1);
          end
        end
        default: state_d = StWaitLow;
      endcase
    end
  end

  always_ff @(posedge clk_Pulse or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StWaitLow;
      wcnt_q      <= '0;
      pcnt_q      <= '0;
      sat_q       <= 1'b0;
      seen_rise_q <= 1'b0;
      width_q     <= '0;
      period_q    <= '0;
      wvalid_q    <= 1'b0;
      pvalid_q    <= 1'b0;
      ok_q        <= 1'b0;
      short_q     <= 1'b0;
      long_q      <= 1'b0;
      pulse_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      pcnt_q      <= pcnt_d;
      sat_q       <= sat_d;
      seen_rise_q <= seen_rise_d;
      width_q     <= width_d;
      period_q    <= period_d;
      wvalid_q    <= wvalid_d;
      pvalid_q    <= pvalid_d;
      ok_q        <= ok_d;
      short_q     <= short_d;
      long_q      <= long_d;
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

  assign width        = width_q;
  assign width_valid  = wvalid_q;
  assign width_ok     = ok_q;
  assign err_short    = short_q;
  assign err_long     = long_q;
  assign period       = period_q;
  assign period_valid = pvalid_q;
  assign pulse_cnt    = pulse_cnt_q;
  assign busy         = (state_q == StHigh);

endmodule
